control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the Phase-2 datapath. It fetches each instruction and sequences one instruction at a time by driving the datapath's `enable`, `busSelect`, `Control_Signals`, `Gra/Grb/Grc`, `Rin/Rout/BAout` and RAM strobes. Conditional branches are resolved from `CONFFOut`. It replaces the hand-written T-state stimulus in the datapath benches and sits beside `datapath` in the CPU top level.

## Interface
- No parameters. Opcodes, bit indices, ALU op codes and states are constants in the package.
- `clk` in 1: system clock; all state changes on rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `ir` in 32: IR contents from datapath; opcode is `ir[31:27]`.
- `CONFFOut` in 1: CON flip-flop output.
- `enable` out 32: register load strobes. 18=Zin, 19=Yin, 20=PCin, 21=MDRin, 23=OutPortin, 24=IRin, 25=MARin, 27=CONin; all other bits 0.
- `busSelect` out 32: bus source. 19=Zlowout, 20=PCout, 21=MDRout, 22=InPortout, 23=Cout; at most one bit set.
- `Control_Signals` out 5: ALU op. ADD=1, SUB=2, AND=3, OR=4, ROR=5, ROL=6, SHR=7, SHRA=8, SHL=9, INCPC=14; 0 otherwise.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout` out 1 each: select/encode controls.
- `ReadRAM`, `WriteRAM`, `MD_Read` out 1 each: memory controls.
- `run` out 1: 1 except in S_RESET and S_HALT.

## Operation
- States: S_RESET, S_T0–S_T3 (fetch), S_E0–S_E5 (execute), S_HALT.
- Outputs are decoded combinationally from state and `ir` (Moore). Every output not listed for a state is 0.
- S_RESET: all outputs 0; next state is S_T0.
- Fetch:
  - T0: PCout, MARin, INCPC, Zin.
  - T1: Zlowout, PCin, ReadRAM.
  - T2: ReadRAM, MD_Read, MDRin.
  - T3: MDRout, IRin.
  - T3 → E0, except nop → T0, halt → S_HALT, unlisted opcode → T0 (treated as nop).
- ALU reg, opcodes 00011–01011 (add..shl):
  - E0: Grb, Rout, Yin.
  - E1: Grc, Rout, ALU op, Zin.
  - E2: Zlowout, Gra, Rin.
- Immediate, 01100–01110 (addi/andi/ori): E1 uses Cout in place of Grc/Rout (op ADD/AND/OR). Otherwise as ALU reg.
- ldi (00001): as addi, with BAout in place of Rout in E0.
- ld (00000):
  - E0: Grb, BAout, Yin.
  - E1: Cout, ADD, Zin.
  - E2: Zlowout, MARin.
  - E3: ReadRAM.
  - E4: ReadRAM, MD_Read, MDRin.
  - E5: MDRout, Gra, Rin.
- st (00010): E0–E2 as ld. E3: Gra, Rout, MDRin (MD_Read=0). E4: WriteRAM.
- br (10011):
  - E0: Gra, Rout, CONin.
  - E1: PCout, Yin.
  - E2: Cout, ADD, Zin.
  - E3: Zlowout; PCin only if `CONFFOut`=1 in E3.
- jr (10100): E0: Gra, Rout, PCin.
- jal (10101):
  - E0: PCout, Grb, Rin. The assembler encodes Rb=R15.
  - E1: Gra, Rout, PCin.
- in (10110): E0: InPortout, Gra, Rin.
- out (10111): E0: Gra, Rout, OutPortin.
- The last execute step of each instruction returns to T0.
- S_HALT: held until `clr`.

## Timing
- One T-step per clock; each strobe is asserted for exactly one cycle.
- Cycles from T0 to the next T0:
  - nop/illegal: 4
  - jr, in, out: 5
  - jal: 6
  - ALU, imm, ldi: 7
  - br: 8
  - st: 9
  - ld: 10
- RAM read latency is 1 cycle: address from T1/E3, data captured into MDR in T2/E4.
- `CONFFOut` is loaded at the end of E0 and sampled in E3; the branch target lands in PC at the end of E3.
- `clr` asserted in any state forces S_RESET immediately (all outputs 0, `run`=0). Deassertion leads to T0 on the next edge. No partial writes occur after `clr`.
- `ir` must stay stable from the end of T3 through the last execute step; only IRin changes it.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - opcode localparams;
  - `enable`/`busSelect` bit indices;
  - ALU op codes;
  - state encoding (4 bits).
- Sub-module `ctrl_decode`: purely combinational, `ir[31:27]` → instruction class (ALU, IMM, LDI, LD, ST, BR, JR, JAL, IN, OUT, NOP, HALT, ILLEGAL) plus 5-bit ALU op.
- The top holds the state register and the output decode.

## Test plan
- Reset mid-execution: pulse `clr` during E1 of add. Expect all outputs 0 and `run`=0 immediately; T0 strobes (enable[25], busSelect[20], Control_Signals=14, enable[18]) in the 2nd cycle after release.
- Fetch: check IRin occurs exactly in the 4th cycle after S_RESET exit.
- brzr with `ir`=9B000019:
  - `CONFFOut`=1 → enable[20] high in E3, 8-cycle instruction.
  - `CONFFOut`=0 → enable[20] low in E3.
- add (`ir`=18000000): E0–E2 show Grb/Rout/Yin, then Grc/Rout/Control_Signals=1/Zin, then busSelect[19]/Gra/Rin. Next T0 follows 7 cycles after the previous T0.
- ld then st: ld shows ReadRAM for 2 cycles and MDRout+Rin in E5 (10 cycles). st shows WriteRAM in E4 only, with MD_Read=0 in E3 (9 cycles).
- halt (`ir`=D8000000): `run` falls after T3 and stays 0 for 20 cycles with all strobes 0; `clr` restarts fetch.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control unit: opcodes, strobe bit
// indices, ALU op codes, sequencer states and instruction classes.
package cpu_ctrl_pkg;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SHL  = 5'b01011;
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;
  localparam logic [4:0] OPC_BR   = 5'b10011;
  localparam logic [4:0] OPC_JR   = 5'b10100;
  localparam logic [4:0] OPC_JAL  = 5'b10101;
  localparam logic [4:0] OPC_IN   = 5'b10110;
  localparam logic [4:0] OPC_OUT  = 5'b10111;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam int EN_ZIN   = 18;
  localparam int EN_YIN   = 19;
  localparam int EN_PCIN  = 20;
  localparam int EN_MDRIN = 21;
  localparam int EN_OUTP  = 23;
  localparam int EN_IRIN  = 24;
  localparam int EN_MARIN = 25;
  localparam int EN_CONIN = 27;

  localparam int BS_ZLO  = 19;
  localparam int BS_PC   = 20;
  localparam int BS_MDR  = 21;
  localparam int BS_INP  = 22;
  localparam int BS_C    = 23;

  localparam logic [4:0] ALU_NONE  = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd3;
  localparam logic [4:0] ALU_OR    = 5'd4;
  localparam logic [4:0] ALU_INCPC = 5'd14;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_E0    = 4'd5,
    S_E1    = 4'd6,
    S_E2    = 4'd7,
    S_E3    = 4'd8,
    S_E4    = 4'd9,
    S_E5    = 4'd10,
    S_HALT  = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_JR,
    C_JAL, C_IN, C_OUT, C_NOP, C_HALT, C_ILLEGAL
  } cls_t;

  // Index of the final execute step (0 = E0) for each class.
  function automatic logic [2:0] last_step(cls_t c);
    logic [2:0] r;
    r = 3'd0;
    case (c)
      C_JAL:               r = 3'd1;
      C_ALU, C_IMM, C_LDI: r = 3'd2;
      C_BR:                r = 3'd3;
      C_ST:                r = 3'd4;
      C_LD:                r = 3'd5;
      default:             r = 3'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: op_i (ir[31:27]) -> instruction class
// cls_o and the ALU op alu_o used in the arithmetic execute step.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] op_i,
  output cls_t       cls_o,
  output logic [4:0] alu_o
);

  always_comb begin
    cls_o = C_ILLEGAL;
    alu_o = ALU_NONE;
    unique case (1'b1)
      (op_i >= OPC_ADD && op_i <= OPC_SHL): begin
        // add..shl map in order onto ALU codes 1..9
        cls_o = C_ALU;
        alu_o = op_i - 5'd2;
      end
      (op_i == OPC_ADDI): begin cls_o = C_IMM; alu_o = ALU_ADD; end
      (op_i == OPC_ANDI): begin cls_o = C_IMM; alu_o = ALU_AND; end
      (op_i == OPC_ORI):  begin cls_o = C_IMM; alu_o = ALU_OR;  end
      (op_i == OPC_LDI):  begin cls_o = C_LDI; alu_o = ALU_ADD; end
      (op_i == OPC_LD):   begin cls_o = C_LD;  alu_o = ALU_ADD; end
      (op_i == OPC_ST):   begin cls_o = C_ST;  alu_o = ALU_ADD; end
      (op_i == OPC_BR):   begin cls_o = C_BR;  alu_o = ALU_ADD; end
      (op_i == OPC_JR):   cls_o = C_JR;
      (op_i == OPC_JAL):  cls_o = C_JAL;
      (op_i == OPC_IN):   cls_o = C_IN;
      (op_i == OPC_OUT):  cls_o = C_OUT;
      (op_i == OPC_NOP):  cls_o = C_NOP;
      (op_i == OPC_HALT): cls_o = C_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the Phase-2 datapath.
// Ports: clk, clr (async high); ir, CONFFOut in; enable/busSelect strobes,
// Control_Signals ALU op, register select/encode, RAM controls, run out.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        CONFFOut,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic [4:0]  Control_Signals,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        ReadRAM,
  output logic        WriteRAM,
  output logic        MD_Read,
  output logic        run
);

  state_t     state_q;
  cls_t       cls;
  logic [4:0] alu_op;
  logic [3:0] ediff;
  logic [2:0] step;

  ctrl_decode u_dec (
    .op_i  (ir[31:27]),
    .cls_o (cls),
    .alu_o (alu_op)
  );

  // Execute step index; meaningful only in S_E0..S_E5.
  assign ediff = state_q - S_E0;
  assign step  = ediff[2:0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_RESET;
    end else begin
      unique case (state_q)
        S_RESET: state_q <= S_T0;
        S_T0:    state_q <= S_T1;
        S_T1:    state_q <= S_T2;
        S_T2:    state_q <= S_T3;
        S_T3: begin
          unique case (cls)
            C_NOP, C_ILLEGAL: state_q <= S_T0;
            C_HALT:           state_q <= S_HALT;
            default:          state_q <= S_E0;
          endcase
        end
        S_HALT:  state_q <= S_HALT;
        default: begin
          if (step >= last_step(cls))
            state_q <= S_T0;
          else
            state_q <= state_t'(state_q + 4'd1);
        end
      endcase
    end
  end

  always_comb begin
    enable          = '0;
    busSelect       = '0;
    Control_Signals = ALU_NONE;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    BAout    = 1'b0;
    ReadRAM  = 1'b0;
    WriteRAM = 1'b0;
    MD_Read  = 1'b0;
    run = (state_q != S_RESET) && (state_q != S_HALT);
    unique case (state_q)
      S_T0: begin
        busSelect[BS_PC]  = 1'b1;
        enable[EN_MARIN]  = 1'b1;
        Control_Signals   = ALU_INCPC;
        enable[EN_ZIN]    = 1'b1;
      end
      S_T1: begin
        busSelect[BS_ZLO] = 1'b1;
        enable[EN_PCIN]   = 1'b1;
        ReadRAM           = 1'b1;
      end
      S_T2: begin
        ReadRAM          = 1'b1;
        MD_Read          = 1'b1;
        enable[EN_MDRIN] = 1'b1;
      end
      S_T3: begin
        busSelect[BS_MDR] = 1'b1;
        enable[EN_IRIN]   = 1'b1;
      end
      S_E0: begin
        unique case (cls)
          C_ALU, C_IMM: begin
            Grb = 1'b1; Rout = 1'b1; enable[EN_YIN] = 1'b1;
          end
          C_LDI, C_LD, C_ST: begin
            Grb = 1'b1; BAout = 1'b1; enable[EN_YIN] = 1'b1;
          end
          C_BR: begin
            Gra = 1'b1; Rout = 1'b1; enable[EN_CONIN] = 1'b1;
          end
          C_JR: begin
            Gra = 1'b1; Rout = 1'b1; enable[EN_PCIN] = 1'b1;
          end
          C_JAL: begin
            busSelect[BS_PC] = 1'b1; Grb = 1'b1; Rin = 1'b1;
          end
          C_IN: begin
            busSelect[BS_INP] = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          C_OUT: begin
            Gra = 1'b1; Rout = 1'b1; enable[EN_OUTP] = 1'b1;
          end
          default: ;
        endcase
      end
      S_E1: begin
        unique case (cls)
          C_ALU: begin
            Grc = 1'b1; Rout = 1'b1;
            Control_Signals = alu_op; enable[EN_ZIN] = 1'b1;
          end
          C_IMM, C_LDI, C_LD, C_ST: begin
            busSelect[BS_C] = 1'b1;
            Control_Signals = alu_op; enable[EN_ZIN] = 1'b1;
          end
          C_BR: begin
            busSelect[BS_PC] = 1'b1; enable[EN_YIN] = 1'b1;
          end
          C_JAL: begin
            Gra = 1'b1; Rout = 1'b1; enable[EN_PCIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_E2: begin
        unique case (cls)
          C_ALU, C_IMM, C_LDI: begin
            busSelect[BS_ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          C_LD, C_ST: begin
            busSelect[BS_ZLO] = 1'b1; enable[EN_MARIN] = 1'b1;
          end
          C_BR: begin
            busSelect[BS_C] = 1'b1;
            Control_Signals = ALU_ADD; enable[EN_ZIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_E3: begin
        unique case (cls)
          C_LD: ReadRAM = 1'b1;
          C_ST: begin
            Gra = 1'b1; Rout = 1'b1; enable[EN_MDRIN] = 1'b1;
          end
          C_BR: begin
            // branch taken only when the CON flag loaded in E0 is set
            busSelect[BS_ZLO] = 1'b1;
            enable[EN_PCIN]   = CONFFOut;
          end
          default: ;
        endcase
      end
      S_E4: begin
        unique case (cls)
          C_LD: begin
            ReadRAM = 1'b1; MD_Read = 1'b1; enable[EN_MDRIN] = 1'b1;
          end
          C_ST:    WriteRAM = 1'b1;
          default: ;
        endcase
      end
      S_E5: begin
        if (cls == C_LD) begin
          busSelect[BS_MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed + random bench for control_sequencer against a
// step-list reference model of each instruction.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        CONFFOut;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic [4:0]  Control_Signals;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic ReadRAM, WriteRAM, MD_Read, run;

  control_sequencer dut (
    .clk             (clk),
    .clr             (clr),
    .ir              (ir),
    .CONFFOut        (CONFFOut),
    .enable          (enable),
    .busSelect       (busSelect),
    .Control_Signals (Control_Signals),
    .Gra             (Gra),
    .Grb             (Grb),
    .Grc             (Grc),
    .Rin             (Rin),
    .Rout            (Rout),
    .BAout           (BAout),
    .ReadRAM         (ReadRAM),
    .WriteRAM        (WriteRAM),
    .MD_Read         (MD_Read),
    .run             (run)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] en;
    logic [31:0] bs;
    logic [4:0]  cs;
    logic gra, grb, grc, rin, rout, baout;
    logic rd, wr, mdr, run;
  } obs_t;

  obs_t obs;
  assign obs = {enable, busSelect, Control_Signals,
                Gra, Grb, Grc, Rin, Rout, BAout,
                ReadRAM, WriteRAM, MD_Read, run};

  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t expq[$];

  // One expected step: up to two enable bits, one bus source, ALU op,
  // and letter flags a=Gra b=Grb c=Grc i=Rin o=Rout B=BAout
  // r=ReadRAM w=WriteRAM m=MD_Read.
  function automatic obs_t stp(int e1, int e2, int b, int cs, string f);
    obs_t s;
    s = '0;
    s.run = 1'b1;
    if (e1 >= 0) s.en[e1] = 1'b1;
    if (e2 >= 0) s.en[e2] = 1'b1;
    if (b >= 0)  s.bs[b]  = 1'b1;
    s.cs = 5'(cs);
    for (int i = 0; i < f.len(); i++) begin
      case (f[i])
        "a": s.gra   = 1'b1;
        "b": s.grb   = 1'b1;
        "c": s.grc   = 1'b1;
        "i": s.rin   = 1'b1;
        "o": s.rout  = 1'b1;
        "B": s.baout = 1'b1;
        "r": s.rd    = 1'b1;
        "w": s.wr    = 1'b1;
        "m": s.mdr   = 1'b1;
        default: ;
      endcase
    end
    return s;
  endfunction

  function automatic obs_t t0_step();
    return stp(25, 18, 20, 14, "");
  endfunction

  // Full cycle-by-cycle step list of one instruction, T0 onward.
  function automatic void build(logic [4:0] op, logic cf);
    int o;
    o = int'(op);
    expq.delete();
    expq.push_back(t0_step());
    expq.push_back(stp(20, -1, 19, 0, "r"));
    expq.push_back(stp(21, -1, -1, 0, "rm"));
    expq.push_back(stp(24, -1, 21, 0, ""));
    if (o <= 2) begin
      expq.push_back(stp(19, -1, -1, 0, "bB"));
      expq.push_back(stp(18, -1, 23, 1, ""));
    end
    if (o == 1) expq.push_back(stp(-1, -1, 19, 0, "ai"));
    if (o == 0 || o == 2) expq.push_back(stp(25, -1, 19, 0, ""));
    if (o == 0) begin
      expq.push_back(stp(-1, -1, -1, 0, "r"));
      expq.push_back(stp(21, -1, -1, 0, "rm"));
      expq.push_back(stp(-1, -1, 21, 0, "ai"));
    end
    if (o == 2) begin
      expq.push_back(stp(21, -1, -1, 0, "ao"));
      expq.push_back(stp(-1, -1, -1, 0, "w"));
    end
    if (o >= 3 && o <= 14) begin
      expq.push_back(stp(19, -1, -1, 0, "bo"));
      if (o <= 11)
        expq.push_back(stp(18, -1, -1, o - 2, "co"));
      else
        expq.push_back(stp(18, -1, 23, (o == 12) ? 1 : (o == 13) ? 3 : 4, ""));
      expq.push_back(stp(-1, -1, 19, 0, "ai"));
    end
    if (o == 19) begin
      expq.push_back(stp(27, -1, -1, 0, "ao"));
      expq.push_back(stp(19, -1, 20, 0, ""));
      expq.push_back(stp(18, -1, 23, 1, ""));
      expq.push_back(stp(cf ? 20 : -1, -1, 19, 0, ""));
    end
    if (o == 20) expq.push_back(stp(20, -1, -1, 0, "ao"));
    if (o == 21) begin
      expq.push_back(stp(-1, -1, 20, 0, "bi"));
      expq.push_back(stp(20, -1, -1, 0, "ao"));
    end
    if (o == 22) expq.push_back(stp(-1, -1, 22, 0, "ai"));
    if (o == 23) expq.push_back(stp(23, -1, -1, 0, "ao"));
  endfunction

  task automatic chk(obs_t e, string tag);
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, e);
    end
  endtask

  // Entered at the negedge showing T0; leaves at the next T0 negedge.
  task automatic run_instr(logic [31:0] iv, logic cf, string nm);
    ir = iv;
    CONFFOut = cf;
    build(iv[31:27], cf);
    foreach (expq[i]) begin
      chk(expq[i], $sformatf("%s_s%0d", nm, i));
      @(negedge clk);
    end
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] iv;
    clr = 1'b1;
    ir = '0;
    CONFFOut = 1'b0;
    @(negedge clk);
    chk('0, "reset");
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    run_instr(32'h18000000, 1'b0, "add");

    // clr pulse during E1 of add
    ir = 32'h18000000;
    build(5'd3, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      chk(expq[i], $sformatf("addclr_s%0d", i));
      if (i < 5) @(negedge clk);
    end
    clr = 1'b1;
    #1;
    chk('0, "clr_now");
    @(negedge clk);
    chk('0, "clr_hold");
    clr = 1'b0;
    @(negedge clk);

    run_instr(32'h9B000019, 1'b1, "br_t");
    run_instr(32'h9B000019, 1'b0, "br_n");
    run_instr(32'h00800010, 1'b0, "ld");
    run_instr(32'h10800010, 1'b1, "st");
    run_instr(32'hD0000000, 1'b0, "nop");

    for (int k = 0; k < 60; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      iv = {op, 27'($urandom)};
      run_instr(iv, 1'($urandom_range(0, 1)), $sformatf("r%0d_op%0d", k, op));
    end

    run_instr(32'hD8000000, 1'b0, "halt");
    for (int i = 0; i < 20; i++) begin
      chk('0, $sformatf("halted_%0d", i));
      @(negedge clk);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk(t0_step(), "restart_t0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
